// File: rtl/mmult_accel_mac_pipe.sv
// Pipelined multiplier with a dot-product accumulator on its output.
// Products leave the pipeline NUM_STAGE enabled cycles after acceptance.
// Completed sums are registered one cycle later with an overflow flag.
module mmult_accel_mac_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 31,
    parameter int din1_WIDTH = 32,
    parameter int dout_WIDTH = 63,
    parameter int ACC_WIDTH  = 64,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic [ACC_WIDTH-1:0]  acc_dout,
    output logic                  acc_valid,
    output logic                  acc_ovf
);

    localparam int LAST = NUM_STAGE - 1;

    // Reject parameter sets the datapath cannot honour; ID is a tag only.
    if (NUM_STAGE < 1 || NUM_STAGE > 8 || ACC_WIDTH < dout_WIDTH ||
        dout_WIDTH > din0_WIDTH + din1_WIDTH + 2 || ID < 0) begin : g_param_err
        $error("mmult_accel_mac_pipe: illegal parameters (ID=%0d)", ID);
    end

    logic signed [din0_WIDTH:0]   w_a;
    logic signed [din1_WIDTH:0]   w_b;
    logic signed [dout_WIDTH-1:0] w_a_ext;
    logic signed [dout_WIDTH-1:0] w_b_ext;
    logic [dout_WIDTH-1:0]        w_prod;

    logic [dout_WIDTH-1:0]        r_data [NUM_STAGE];
    logic [NUM_STAGE-1:0]         r_vld;
    logic [NUM_STAGE-1:0]         r_fst;
    logic [NUM_STAGE-1:0]         r_lst;

    logic signed [dout_WIDTH:0]   w_p_s;
    logic [ACC_WIDTH-1:0]         w_ext;
    logic [ACC_WIDTH:0]           w_sum_c;
    logic [ACC_WIDTH-1:0]         w_sum;
    logic                         w_add_ovf;
    logic [ACC_WIDTH-1:0]         w_next_acc;
    logic                         w_next_ovf;
    logic                         w_done;

    logic [ACC_WIDTH-1:0]         r_acc;
    logic                         r_ovf;
    logic [ACC_WIDTH-1:0]         r_acc_dout;
    logic                         r_acc_valid;
    logic                         r_acc_ovf;

    // Operand extension and product; only the low dout_WIDTH bits are kept,
    // so the operands are resized to dout_WIDTH before multiplying.
    always_comb begin
        w_a     = {(SIGNED != 0) & din0[din0_WIDTH-1], din0};
        w_b     = {(SIGNED != 0) & din1[din1_WIDTH-1], din1};
        w_a_ext = dout_WIDTH'(w_a);
        w_b_ext = dout_WIDTH'(w_b);
        w_prod  = w_a_ext * w_b_ext;
    end

    // Product pipeline: flags travel with data, data loads only when valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
            r_fst <= '0;
            r_lst <= '0;
            for (int unsigned k = 0; k < NUM_STAGE; k++) begin
                r_data[k] <= '0;
            end
        end else if (ce) begin
            r_vld[0] <= in_valid;
            r_fst[0] <= in_valid & in_first;
            r_lst[0] <= in_valid & in_last;
            if (in_valid) begin
                r_data[0] <= w_prod;
            end
            for (int unsigned k = 1; k < NUM_STAGE; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_fst[k] <= r_fst[k-1];
                r_lst[k] <= r_lst[k-1];
                if (r_vld[k-1]) begin
                    r_data[k] <= r_data[k-1];
                end
            end
        end
    end

    assign dout       = r_data[LAST];
    assign dout_valid = r_vld[LAST];

    // Next accumulator value and running overflow for the product on dout.
    always_comb begin
        w_p_s      = {(SIGNED != 0) & dout[dout_WIDTH-1], dout};
        w_ext      = ACC_WIDTH'(w_p_s);
        w_sum_c    = {1'b0, r_acc} + {1'b0, w_ext};
        w_sum      = w_sum_c[ACC_WIDTH-1:0];
        if (SIGNED != 0) begin
            w_add_ovf = (r_acc[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1]) &&
                        (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
        end else begin
            w_add_ovf = w_sum_c[ACC_WIDTH];
        end
        w_next_acc = r_fst[LAST] ? w_ext : w_sum;
        w_next_ovf = r_fst[LAST] ? 1'b0 : (r_ovf | w_add_ovf);
        w_done     = r_vld[LAST] & r_lst[LAST];
    end

    // Accumulator and completed-sum registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_acc_dout  <= '0;
            r_acc_valid <= 1'b0;
            r_acc_ovf   <= 1'b0;
        end else if (ce) begin
            if (r_vld[LAST]) begin
                r_acc <= w_next_acc;
                r_ovf <= w_next_ovf;
            end
            r_acc_valid <= w_done;
            if (w_done) begin
                r_acc_dout <= w_next_acc;
                r_acc_ovf  <= w_next_ovf;
            end
        end
    end

    assign acc_dout  = r_acc_dout;
    assign acc_valid = r_acc_valid;
    assign acc_ovf   = r_acc_ovf;

endmodule

// File: doc/mmult_accel_mac_pipe.md
MMULT_ACCEL_MAC_PIPE -- requirements
Module: mmult_accel_mac_pipe

Interface
REQ-001 SHALL have parameter ID, default 1, instance identifier with no functional effect.
REQ-002 SHALL have parameter NUM_STAGE, default 3, multiplier pipeline depth; legal range 1..8.
REQ-003 SHALL have parameter din0_WIDTH, default 31, operand A width.
REQ-004 SHALL have parameter din1_WIDTH, default 32, operand B width.
REQ-005 SHALL have parameter dout_WIDTH, default 63, product width: low bits of the full product.
REQ-006 SHALL have parameter ACC_WIDTH, default 64, accumulator width; must be at least dout_WIDTH.
REQ-007 SHALL have parameter SIGNED, default 0: 0 zero-extends both operands, 1 sign-extends both operands.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port ce, input, 1 bit: clock enable; when 0, all pipeline and accumulator state holds.
REQ-011 SHALL have port in_valid, input, 1 bit: operands present this cycle.
REQ-012 SHALL have port in_first, input, 1 bit: first term of a dot product; accumulator restarts.
REQ-013 SHALL have port in_last, input, 1 bit: final term of a dot product.
REQ-014 SHALL have port din0, input, din0_WIDTH bits: operand A.
REQ-015 SHALL have port din1, input, din1_WIDTH bits: operand B.
REQ-016 SHALL have port dout, output, dout_WIDTH bits: registered product.
REQ-017 SHALL have port dout_valid, output, 1 bit: dout holds a product.
REQ-018 SHALL have port acc_dout, output, ACC_WIDTH bits: completed dot-product sum.
REQ-019 SHALL have port acc_valid, output, 1 bit: acc_dout holds a completed sum.
REQ-020 SHALL have port acc_ovf, output, 1 bit: overflow occurred in the sum currently on acc_dout.

Function
REQ-021 SHALL accept operands when ce=1 and in_valid=1; in_valid, in_first and in_last are ignored when ce=0.
REQ-022 SHALL form the product as ({SIGNED ? din0 MSB : 0, din0} times {SIGNED ? din1 MSB : 0, din1}) in signed arithmetic, then truncate to the low dout_WIDTH bits.
REQ-023 SHALL present the product on dout with dout_valid=1 exactly NUM_STAGE ce=1 cycles after acceptance.
REQ-024 SHALL carry valid, first and last flags alongside the data through every stage.
REQ-025 SHALL hold all stages, dout, dout_valid, acc_dout, acc_valid and acc_ovf when ce=0; a stall never drops or duplicates a term.
REQ-026 SHALL hold dout at its last value while dout_valid=0.
REQ-027 SHALL, for each product with dout_valid=1 and ce=1, extend the product to ACC_WIDTH (sign-extend if SIGNED=1, else zero-extend).
REQ-028 SHALL, in that case, load the accumulator with the extended product if the product's first flag is set, and otherwise add the extended product to the accumulator.
REQ-029 SHALL perform accumulator addition modulo 2^ACC_WIDTH (wrap-around).
REQ-030 SHALL track a running overflow bit: cleared on a first term, and set on any subsequent add that produces an unsigned carry-out (SIGNED=0) or a two's-complement overflow (SIGNED=1).
REQ-031 SHALL, when a product carrying the last flag is absorbed, register the updated sum on acc_dout and its overflow bit on acc_ovf, and assert acc_valid for one ce=1 cycle (latency NUM_STAGE+1 from acceptance of the last term).
REQ-032 SHALL deassert acc_valid on the next ce=1 cycle unless another last term completes, and SHALL hold acc_dout and acc_ovf until the next completion.
REQ-033 SHALL, when first and last are set on the same term, produce acc_dout equal to that term's extended product with acc_ovf=0.
REQ-034 SHALL, for a term with neither flag set and no prior first term since reset, add it to the current accumulator value (0 after reset).
REQ-035 SHALL accept back-to-back dot products at full rate: a last term followed immediately by a first term loses no data.

Reset
REQ-036 SHALL, on reset=1 at a clock edge, clear all valid/first/last flags, dout, dout_valid, the accumulator, acc_dout, acc_valid and acc_ovf to 0, regardless of ce.
REQ-037 SHALL discard all in-flight terms on reset mid-operation; the first accepted term after reset deasserts is processed normally.

Verification
REQ-038 SHALL pass this scenario: SIGNED=0, NUM_STAGE=3; din0=7, din1=6 with first=last=1 -> dout=42 after 3 cycles; acc_dout=42, acc_valid pulse after 4 cycles, acc_ovf=0.
REQ-039 SHALL pass this scenario: SIGNED=1; terms (-3,5), (2,4), (-1,-1), flags first, -, last, back-to-back -> acc_dout=-6 (all ones in the upper bits), one acc_valid pulse.
REQ-040 SHALL pass this scenario: ce=0 for 5 cycles in the middle of the REQ-039 stream -> same results, with acc_valid delayed by 5 cycles and outputs held throughout the stall.
REQ-041 SHALL pass this scenario: ACC_WIDTH=dout_WIDTH=8, SIGNED=0, din widths 4; terms 15*15 then 15*15 with last -> acc_dout=194, acc_ovf=1; the next dot product 1*1 with first=last=1 -> 1, acc_ovf=0.
REQ-042 SHALL pass this scenario: reset asserted with 2 terms in flight -> no dout_valid or acc_valid for those terms; all outputs read 0 on the next cycle.
REQ-043 SHALL pass this scenario: dot products (2,3) with first=last=1 and (4,5) with first=last=1 on consecutive cycles -> acc_valid high on two consecutive cycles, acc_dout=6 then 20.
